// File: rtl/gcn_argmax_reader.sv
// Final GCN stage: row-wise argmax over the combination scratch pad.
// Ports: clk/reset, start, scratch-pad read (read_en/row/col/data),
// result stream (out_valid/ready/row/class), max_addi_answer, done.
// Optional ARGMAX_SIGNED_EN: compare class scores as signed values.
module gcn_argmax_reader #(
  parameter int FEATURE_ROWS   = 6,
  parameter int WEIGHT_COLS    = 3,
  parameter int DOT_PROD_WIDTH = 16,
  parameter int ROW_WIDTH      = $clog2(FEATURE_ROWS),
  parameter int COL_WIDTH      = $clog2(WEIGHT_COLS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  output logic                          read_en,
  output logic [ROW_WIDTH-1:0]          read_row,
  output logic [COL_WIDTH-1:0]          read_col,
  input  logic [DOT_PROD_WIDTH-1:0]     read_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ROW_WIDTH-1:0]          out_row,
  output logic [COL_WIDTH-1:0]          out_class,
  output logic [FEATURE_ROWS*COL_WIDTH-1:0] max_addi_answer,
  output logic                          done
);

  localparam logic [ROW_WIDTH-1:0] LAST_ROW =
    ROW_WIDTH'(FEATURE_ROWS - 1);
  localparam logic [COL_WIDTH-1:0] LAST_COL =
    COL_WIDTH'(WEIGHT_COLS - 1);

  typedef enum logic [2:0] {
    IDLE, REQ, CMP, EMIT, DONE
  } state_t;

  state_t state_q, state_d;
  logic [ROW_WIDTH-1:0]      row_q, row_d;
  logic [COL_WIDTH-1:0]      col_q, col_d;
  logic [DOT_PROD_WIDTH-1:0] max_val_q, max_val_d;
  logic [COL_WIDTH-1:0]      max_idx_q, max_idx_d;

  logic                 read_en_q, read_en_d;
  logic [ROW_WIDTH-1:0] read_row_q, read_row_d;
  logic [COL_WIDTH-1:0] read_col_q, read_col_d;
  logic                 out_valid_q, out_valid_d;
  logic [ROW_WIDTH-1:0] out_row_q, out_row_d;
  logic [COL_WIDTH-1:0] out_class_q, out_class_d;
  logic [FEATURE_ROWS*COL_WIDTH-1:0] ans_q, ans_d;
  logic                 done_q, done_d;

  logic gt;

  // Strict greater-than keeps the lowest column on ties.
`ifdef ARGMAX_SIGNED_EN
  assign gt = $signed(read_data) > $signed(max_val_q);
`else
  assign gt = read_data > max_val_q;
`endif

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    max_val_d = max_val_q;
    max_idx_d = max_idx_q;
    ans_d     = ans_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = REQ;
          row_d   = '0;
          col_d   = '0;
        end
      end
      REQ: state_d = CMP;
      CMP: begin
        if (col_q == '0 || gt) begin
          max_val_d = read_data;
          max_idx_d = col_q;
        end
        if (col_q == LAST_COL) begin
          state_d = EMIT;
        end else begin
          col_d   = col_q + 1'b1;
          state_d = REQ;
        end
      end
      EMIT: begin
        if (out_ready) begin
          ans_d[row_q*COL_WIDTH +: COL_WIDTH] = max_idx_q;
          if (row_q == LAST_ROW) begin
            state_d = DONE;
          end else begin
            row_d   = row_q + 1'b1;
            col_d   = '0;
            state_d = REQ;
          end
        end
      end
      DONE: state_d = DONE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they
    // line up with state_q in the following cycle.
    read_en_d  = (state_d == REQ);
    read_row_d = read_row_q;
    read_col_d = read_col_q;
    if (state_d == REQ) begin
      read_row_d = row_d;
      read_col_d = col_d;
    end
    out_valid_d = (state_d == EMIT);
    out_row_d   = (state_d == EMIT) ? row_d : '0;
    out_class_d = (state_d == EMIT) ? max_idx_d : '0;
    done_d      = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      row_q       <= '0;
      col_q       <= '0;
      max_val_q   <= '0;
      max_idx_q   <= '0;
      read_en_q   <= 1'b0;
      read_row_q  <= '0;
      read_col_q  <= '0;
      out_valid_q <= 1'b0;
      out_row_q   <= '0;
      out_class_q <= '0;
      ans_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      max_val_q   <= max_val_d;
      max_idx_q   <= max_idx_d;
      read_en_q   <= read_en_d;
      read_row_q  <= read_row_d;
      read_col_q  <= read_col_d;
      out_valid_q <= out_valid_d;
      out_row_q   <= out_row_d;
      out_class_q <= out_class_d;
      ans_q       <= ans_d;
      done_q      <= done_d;
    end
  end

  assign read_en         = read_en_q;
  assign read_row        = read_row_q;
  assign read_col        = read_col_q;
  assign out_valid       = out_valid_q;
  assign out_row         = out_row_q;
  assign out_class       = out_class_q;
  assign max_addi_answer = ans_q;
  assign done            = done_q;

endmodule

// File: tb/tb_gcn_argmax_reader.sv
// Scoreboard bench for gcn_argmax_reader: scratch-pad model,
// directed pads, backpressure, mid-run reset and sticky done.
module tb_gcn_argmax_reader;

  localparam int FR = 6;
  localparam int WC = 3;
  localparam int DW = 16;
  localparam int RW = $clog2(FR);
  localparam int CW = $clog2(WC);

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic read_en;
  logic [RW-1:0] read_row;
  logic [CW-1:0] read_col;
  logic [DW-1:0] read_data;
  logic out_valid;
  logic out_ready;
  logic [RW-1:0] out_row;
  logic [CW-1:0] out_class;
  logic [FR*CW-1:0] max_addi_answer;
  logic done;

  gcn_argmax_reader #(
    .FEATURE_ROWS(FR), .WEIGHT_COLS(WC), .DOT_PROD_WIDTH(DW)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .read_en(read_en), .read_row(read_row), .read_col(read_col),
    .read_data(read_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_row(out_row),
    .out_class(out_class), .max_addi_answer(max_addi_answer),
    .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int row;
    int cls;
  } exp_t;

  exp_t exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cur_pad = 0;

  logic [DW-1:0] pads [2][FR][WC];
  int exp_cls [2][FR];

  // Scratch-pad model: data valid one cycle after read_en.
  always @(posedge clk) begin
    if (read_en && int'(read_row) < FR && int'(read_col) < WC)
      read_data <= pads[cur_pad][read_row][read_col];
  end

  // Monitor: every accepted result is checked against the queue.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      n_tests++;
      if (read_en) begin
        n_fail++;
        $display("FAIL emit_no_read: read_en=%0b required 0", read_en);
      end
    end
    if (!reset && out_valid && out_ready) begin
      exp_t e;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: row=%0d class=%0d, none expected",
                 out_row, out_class);
      end else begin
        e = exp_q.pop_front();
        if (int'(out_row) != e.row || int'(out_class) != e.cls) begin
          n_fail++;
          $display("FAIL sb_result: row=%0d class=%0d required row=%0d class=%0d",
                   out_row, out_class, e.row, e.cls);
        end
      end
    end
  end

  task automatic chk(input string name, input longint act,
                     input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string name);
    chk(name, {read_en, read_row, read_col, out_valid, out_row,
               out_class, max_addi_answer, done}, 0);
  endtask

  function automatic logic [FR*CW-1:0] exp_vec(input int p);
    logic [FR*CW-1:0] v = '0;
    for (int r = 0; r < FR; r++)
      v[r*CW +: CW] = CW'(exp_cls[p][r]);
    return v;
  endfunction

  task automatic push_exp(input int p);
    for (int r = 0; r < FR; r++) begin
      exp_t e;
      e.row = r;
      e.cls = exp_cls[p][r];
      exp_q.push_back(e);
    end
  endtask

  // Called just after a posedge; start is sampled at the next edge.
  task automatic run_pad(input int p, input int bp_row, input int bp_n,
                         input bit drop_start, output int cyc,
                         output int stalls);
    logic [CW-1:0] held;
    held = '0;
    cur_pad = p;
    push_exp(p);
    start = 1'b1;
    out_ready = 1'b1;
    cyc = 0;
    stalls = 0;
    while (cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      if (drop_start) start = 1'b0;
      if (done) break;
      if (out_valid && int'(out_row) == bp_row && stalls < bp_n) begin
        if (stalls == 0) begin
          held = out_class;
        end else begin
          chk("bp_class_hold", out_class, held);
          chk("bp_read_en", read_en, 0);
        end
        out_ready = 1'b0;
        stalls++;
      end else begin
        out_ready = 1'b1;
      end
    end
    start = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    chk_zero("reset_state");
    exp_q.delete();
    reset = 1'b0;
  endtask

  int cyc, stalls;
  bit seen;

  initial begin
    pads[0][0] = '{16'd5, 16'd9, 16'd2}; exp_cls[0][0] = 1;
    pads[0][1] = '{16'd1, 16'd0, 16'd4}; exp_cls[0][1] = 2;
    pads[0][2] = '{16'd8, 16'd3, 16'd8}; exp_cls[0][2] = 0;
    pads[0][3] = '{16'd0, 16'd0, 16'd0}; exp_cls[0][3] = 0;
    pads[0][4] = '{16'd2, 16'd7, 16'd7}; exp_cls[0][4] = 1;
    pads[0][5] = '{16'd3, 16'd1, 16'd2}; exp_cls[0][5] = 0;

    pads[1][0] = '{16'd7, 16'd7, 16'd3}; exp_cls[1][0] = 0;
    pads[1][1] = '{16'd0, 16'd0, 16'd0}; exp_cls[1][1] = 0;
    pads[1][2] = '{16'hFFFF, 16'd3, 16'd0};
`ifdef ARGMAX_SIGNED_EN
    exp_cls[1][2] = 1;
`else
    exp_cls[1][2] = 0;
`endif
    pads[1][3] = '{16'd1, 16'd2, 16'd3}; exp_cls[1][3] = 2;
    pads[1][4] = '{16'd3, 16'd2, 16'd1}; exp_cls[1][4] = 0;
    pads[1][5] = '{16'd0, 16'd5, 16'd4}; exp_cls[1][5] = 1;

    read_data = '0;
    out_ready = 1'b1;
    reset = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Basic run.
    run_pad(0, -1, 0, 1'b0, cyc, stalls);
    chk("basic_latency", cyc, 43);
    chk("basic_answer", max_addi_answer, exp_vec(0));
    chk("basic_sb_empty", exp_q.size(), 0);

    // Sticky done while start toggles.
    for (int i = 0; i < 5; i++) begin
      start = (i == 1 || i == 2);
      @(posedge clk);
      #1;
      chk("sticky_done", {done, read_en, out_valid}, 3'b100);
    end
    start = 1'b0;

    // Ties and sign handling; start dropped after sampling.
    do_reset();
    run_pad(1, -1, 0, 1'b1, cyc, stalls);
    chk("ties_latency", cyc, 43);
    chk("ties_answer", max_addi_answer, exp_vec(1));
    chk("ties_sb_empty", exp_q.size(), 0);

    // Backpressure on row 2 for 3 cycles.
    do_reset();
    run_pad(0, 2, 3, 1'b0, cyc, stalls);
    chk("bp_latency", cyc, 46);
    chk("bp_stalls", stalls, 3);
    chk("bp_answer", max_addi_answer, exp_vec(0));

    // Reset while in CMP of row 3, column 1.
    do_reset();
    cur_pad = 0;
    push_exp(0);
    start = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (read_en && read_row == 3'd3 && read_col == 2'd1)
        seen = 1'b1;
    end
    chk("midrst_reached", seen, 1);
    @(posedge clk);
    #1;
    chk("midrst_pending", exp_q.size(), 3);
    reset = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    chk_zero("midrst_zero");
    exp_q.delete();
    reset = 1'b0;
    run_pad(0, -1, 0, 1'b0, cyc, stalls);
    chk("rerun_latency", cyc, 43);
    chk("rerun_answer", max_addi_answer, exp_vec(0));
    chk("rerun_sb_empty", exp_q.size(), 0);

    @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
